// File: rtl/intersection_ctrl.sv
// intersection_ctrl: N-approach traffic-intersection controller.
// Serves one approach at a time in demand-driven round-robin order, latches
// vehicle/pedestrian requests, holds green while nobody else is waiting and
// falls back to a flashing-yellow night mode on request.
module intersection_ctrl #(
    parameter int unsigned NUM_DIR      = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned T_ALL_RED    = 2,
    parameter int unsigned T_RED_YELLOW = 30_000_000,
    parameter int unsigned T_GREEN      = 30_000_000,
    parameter int unsigned T_YELLOW     = 30_000_000,
    parameter int unsigned T_FLASH      = 25_000_000,
    localparam int unsigned DIR_W       = $clog2(NUM_DIR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_DIR-1:0] request,
    input  logic               flash_mode,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [DIR_W-1:0]   active_dir,
    output logic [2:0]         phase
);

    typedef enum logic [2:0] {
        PH_ALL_RED    = 3'd0,
        PH_RED_YELLOW = 3'd1,
        PH_GREEN      = 3'd2,
        PH_YELLOW     = 3'd3,
        PH_FLASH      = 3'd4
    } phase_t;

    // Terminal counter values: a phase of length T ends when the counter reads T-1.
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] RY_LAST  = CNT_W'(T_RED_YELLOW - 1);
    localparam logic [CNT_W-1:0] GR_LAST  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] YE_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(T_FLASH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    phase_t             phase_q;
    phase_t             phase_d;
    logic [DIR_W-1:0]   dir_q;
    logic [DIR_W-1:0]   dir_d;
    logic [DIR_W-1:0]   next_dir;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [NUM_DIR-1:0] pending_q;
    logic [NUM_DIR-1:0] pending_d;
    logic [NUM_DIR-1:0] req_mask;
    logic [NUM_DIR-1:0] dir_onehot;
    logic               other_demand;
    logic               blink_q;
    logic               blink_d;

    assign dir_onehot   = NUM_DIR'(1) << dir_q;
    assign other_demand = |(pending_q & ~dir_onehot);

    // State register; asynchronous reset drops every in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= PH_ALL_RED;
            dir_q     <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            blink_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            blink_q   <= blink_d;
        end
    end

    // Round-robin search: first pending approach after the current one, wrapping.
    always_comb begin
        int unsigned idx;
        logic        found;
        logic [DIR_W-1:0] idx_s;
        next_dir = dir_q;
        found    = 1'b0;
        idx      = 0;
        idx_s    = '0;
        for (int unsigned k = 1; k <= NUM_DIR; k++) begin
            idx   = (32'(dir_q) + k) % NUM_DIR;
            idx_s = DIR_W'(idx);
            if (!found && pending_q[idx_s]) begin
                found    = 1'b1;
                next_dir = idx_s;
            end
        end
    end

    // Next-state logic: phase sequencing, request latching and blink timing.
    always_comb begin
        phase_d  = phase_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q + CNT_ONE;
        blink_d  = blink_q;
        req_mask = request;
        if (phase_q == PH_GREEN) begin
            req_mask[dir_q] = 1'b0;
        end
        pending_d = pending_q | req_mask;

        case (phase_q)
            PH_ALL_RED: begin
                if (cnt_q == AR_LAST) begin
                    cnt_d = '0;
                    if (flash_mode) begin
                        phase_d = PH_FLASH;
                        blink_d = 1'b1;
                    end else begin
                        phase_d = PH_RED_YELLOW;
                        dir_d   = next_dir;
                    end
                end
            end
            PH_RED_YELLOW: begin
                if (cnt_q == RY_LAST) begin
                    phase_d          = PH_GREEN;
                    cnt_d            = '0;
                    // Served on entry; overrides a request sampled on this same edge.
                    pending_d[dir_q] = 1'b0;
                end
            end
            PH_GREEN: begin
                if (cnt_q >= GR_LAST) begin
                    if (other_demand || flash_mode) begin
                        phase_d = PH_YELLOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = GR_LAST;
                    end
                end
            end
            PH_YELLOW: begin
                if (cnt_q == YE_LAST) begin
                    phase_d = PH_ALL_RED;
                    cnt_d   = '0;
                end
            end
            PH_FLASH: begin
                if (!flash_mode) begin
                    phase_d = PH_ALL_RED;
                    cnt_d   = '0;
                end else if (cnt_q == FL_LAST) begin
                    blink_d = ~blink_q;
                    cnt_d   = '0;
                end
            end
            default: begin
                phase_d = PH_ALL_RED;
                cnt_d   = '0;
            end
        endcase
    end

    // Lamp decode from registered state only.
    always_comb begin
        red    = '0;
        yellow = '0;
        green  = '0;
        case (phase_q)
            PH_ALL_RED: begin
                red = '1;
            end
            PH_RED_YELLOW: begin
                red    = '1;
                yellow = dir_onehot;
            end
            PH_GREEN: begin
                green = dir_onehot;
                red   = ~dir_onehot;
            end
            PH_YELLOW: begin
                yellow = dir_onehot;
                red    = ~dir_onehot;
            end
            PH_FLASH: begin
                yellow = {NUM_DIR{blink_q}};
            end
            default: begin
                red = '1;
            end
        endcase
    end

    assign active_dir = dir_q;
    assign phase      = phase_q;

    a_green_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(green));
    a_no_red_green: assert property (@(posedge clk) disable iff (!rst_n) (red & green) == '0);

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed-vector bench for intersection_ctrl with
// NUM_DIR=3 and short phase timings; expected lamp states are hand-computed.
module tb_intersection_ctrl;

    localparam logic [2:0] PH_AR = 3'd0;
    localparam logic [2:0] PH_RY = 3'd1;
    localparam logic [2:0] PH_GR = 3'd2;
    localparam logic [2:0] PH_YE = 3'd3;
    localparam logic [2:0] PH_FL = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] request;
    logic       flash_mode;
    logic [2:0] red;
    logic [2:0] yellow;
    logic [2:0] green;
    logic [1:0] active_dir;
    logic [2:0] phase;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    intersection_ctrl #(
        .NUM_DIR      (3),
        .CNT_W        (8),
        .T_ALL_RED    (2),
        .T_RED_YELLOW (2),
        .T_GREEN      (8),
        .T_YELLOW     (3),
        .T_FLASH      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .request    (request),
        .flash_mode (flash_mode),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .active_dir (active_dir),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle k's state is visible between rising edges k-1 and k; sample 1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int k);
        while (cyc < k) step();
    endtask

    task automatic expect_st(input string tag, input logic [2:0] ph, input logic [1:0] dir,
                             input logic [2:0] r, input logic [2:0] y, input logic [2:0] g);
        check(tag, {2'b00, phase, active_dir, red, yellow, green},
                   {2'b00, ph, dir, r, y, g});
    endtask

    task automatic span(input string tag, input int a, input int b, input logic [2:0] ph,
                        input logic [1:0] dir, input logic [2:0] r, input logic [2:0] y,
                        input logic [2:0] g);
        for (int k = a; k <= b; k++) begin
            goto(k);
            expect_st($sformatf("%s c%0d", tag, k), ph, dir, r, y, g);
        end
    endtask

    task automatic chk_pend(input string tag, input logic [2:0] exp);
        check(tag, {13'd0, dut.pending_q}, {13'd0, exp});
    endtask

    task automatic do_reset(input string tag);
        rst_n      = 1'b0;
        request    = '0;
        flash_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_st({tag, " reset"}, PH_AR, 2'd0, 3'b111, 3'b000, 3'b000);
        chk_pend({tag, " reset pend"}, 3'b000);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        rst_n      = 1'b0;
        request    = '0;
        flash_mode = 1'b0;

        // 1: no requests, green hold on dir0
        do_reset("s1");
        span("s1 ar", 0, 1,   PH_AR, 2'd0, 3'b111, 3'b000, 3'b000);
        span("s1 ry", 2, 3,   PH_RY, 2'd0, 3'b111, 3'b001, 3'b000);
        span("s1 gr", 4, 100, PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);

        // 2: single request on dir2
        do_reset("s2");
        span("s2 gr0", 4, 5, PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);
        request = 3'b100;
        goto(6);
        request = 3'b000;
        chk_pend("s2 pend c6", 3'b100);
        span("s2 gr0", 6, 11,  PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);
        span("s2 ye0", 12, 14, PH_YE, 2'd0, 3'b110, 3'b001, 3'b000);
        span("s2 ar",  15, 16, PH_AR, 2'd0, 3'b111, 3'b000, 3'b000);
        span("s2 ry2", 17, 18, PH_RY, 2'd2, 3'b111, 3'b100, 3'b000);
        span("s2 gr2", 19, 19, PH_GR, 2'd2, 3'b011, 3'b000, 3'b100);
        chk_pend("s2 pend c19", 3'b000);

        // 3: round-robin wrap from dir2; own request held during green is ignored
        request = 3'b100;
        goto(20);
        request = 3'b111;
        goto(21);
        request = 3'b100;
        chk_pend("s3 pend c21", 3'b011);
        span("s3 gr2", 21, 26, PH_GR, 2'd2, 3'b011, 3'b000, 3'b100);
        goto(27);
        request = 3'b000;
        span("s3 ye2", 27, 29, PH_YE, 2'd2, 3'b011, 3'b100, 3'b000);
        span("s3 ar",  30, 31, PH_AR, 2'd2, 3'b111, 3'b000, 3'b000);
        span("s3 ry0", 32, 33, PH_RY, 2'd0, 3'b111, 3'b001, 3'b000);
        span("s3 gr0", 34, 34, PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);
        chk_pend("s3 pend c34", 3'b010);
        span("s3 gr0", 35, 41, PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);
        span("s3 ye0", 42, 44, PH_YE, 2'd0, 3'b110, 3'b001, 3'b000);
        span("s3 ar",  45, 46, PH_AR, 2'd0, 3'b111, 3'b000, 3'b000);
        span("s3 ry1", 47, 48, PH_RY, 2'd1, 3'b111, 3'b010, 3'b000);
        span("s3 gr1", 49, 70, PH_GR, 2'd1, 3'b101, 3'b000, 3'b010);
        chk_pend("s3 pend c70", 3'b000);

        // 4: flash mode entry and exit
        do_reset("s4");
        span("s4 gr0", 4, 5, PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);
        goto(6);
        flash_mode = 1'b1;
        span("s4 gr0", 6, 11,  PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);
        span("s4 ye0", 12, 14, PH_YE, 2'd0, 3'b110, 3'b001, 3'b000);
        span("s4 ar",  15, 16, PH_AR, 2'd0, 3'b111, 3'b000, 3'b000);
        span("s4 fl1", 17, 20, PH_FL, 2'd0, 3'b000, 3'b111, 3'b000);
        span("s4 fl0", 21, 24, PH_FL, 2'd0, 3'b000, 3'b000, 3'b000);
        span("s4 fl1", 25, 28, PH_FL, 2'd0, 3'b000, 3'b111, 3'b000);
        flash_mode = 1'b0;
        span("s4 ar",  29, 30, PH_AR, 2'd0, 3'b111, 3'b000, 3'b000);
        span("s4 ry0", 31, 32, PH_RY, 2'd0, 3'b111, 3'b001, 3'b000);
        span("s4 gr0", 33, 33, PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);

        // 5: asynchronous reset in the middle of YELLOW
        do_reset("s5");
        span("s5 gr0", 4, 5, PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);
        request = 3'b010;
        goto(6);
        request = 3'b000;
        span("s5 gr0", 6, 11,  PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);
        span("s5 ye0", 12, 13, PH_YE, 2'd0, 3'b110, 3'b001, 3'b000);
        chk_pend("s5 pend pre", 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        expect_st("s5 async", PH_AR, 2'd0, 3'b111, 3'b000, 3'b000);
        chk_pend("s5 async pend", 3'b000);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
        span("s5 ar",  0, 1,  PH_AR, 2'd0, 3'b111, 3'b000, 3'b000);
        span("s5 ry0", 2, 3,  PH_RY, 2'd0, 3'b111, 3'b001, 3'b000);
        span("s5 gr0", 4, 20, PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);

        // 6: same-edge request corner cases
        do_reset("s6");
        goto(3);
        request = 3'b001;
        goto(5);
        request = 3'b000;
        chk_pend("s6 pend c5", 3'b000);
        span("s6 gr0", 5, 12, PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);
        request = 3'b100;
        goto(13);
        request = 3'b000;
        span("s6 gr0", 13, 13, PH_GR, 2'd0, 3'b110, 3'b000, 3'b001);
        span("s6 ye0", 14, 16, PH_YE, 2'd0, 3'b110, 3'b001, 3'b000);
        span("s6 ar",  17, 18, PH_AR, 2'd0, 3'b111, 3'b000, 3'b000);
        request = 3'b010;
        goto(19);
        request = 3'b000;
        chk_pend("s6 pend c19", 3'b110);
        span("s6 ry2", 19, 20, PH_RY, 2'd2, 3'b111, 3'b100, 3'b000);
        goto(21);
        chk_pend("s6 pend c21", 3'b010);
        span("s6 gr2", 21, 28, PH_GR, 2'd2, 3'b011, 3'b000, 3'b100);
        span("s6 ye2", 29, 31, PH_YE, 2'd2, 3'b011, 3'b100, 3'b000);
        span("s6 ar",  32, 33, PH_AR, 2'd2, 3'b111, 3'b000, 3'b000);
        span("s6 ry1", 34, 35, PH_RY, 2'd1, 3'b111, 3'b010, 3'b000);
        span("s6 gr1", 36, 40, PH_GR, 2'd1, 3'b101, 3'b000, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/intersection_ctrl.md
# intersection_ctrl

Parametrised N-approach traffic-intersection controller driving one Red/Yellow/Green lamp set per approach. Grants green to one approach at a time in demand-driven round-robin order, with a separate programmable duration per phase, latched vehicle/pedestrian requests, green hold when there is no competing demand, and a flashing-yellow night mode. It sits directly behind the board push-button/sensor synchronisers and drives the lamp LEDs. It replaces the fixed single-approach four-phase light.

## Interface
- NUM_DIR, 4: number of approaches, 2..8.
- CNT_W, 32: phase counter width; must hold max(T_*)-1.
- T_ALL_RED, 2: ALL_RED phase length in cycles, ≥1.
- T_RED_YELLOW, 30_000_000: RED_YELLOW phase length in cycles, ≥1.
- T_GREEN, 30_000_000: minimum GREEN length in cycles, ≥1.
- T_YELLOW, 30_000_000: YELLOW phase length in cycles, ≥1.
- T_FLASH, 25_000_000: flash half-period in cycles, ≥1.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset_N  in  1  asynchronous, active-low reset.
- Request  in  NUM_DIR  per-approach demand. Level or pulse; already synchronised.
- FlashMode  in  1  night/fault mode request, level.
- Red, Yellow, Green  out  NUM_DIR each  lamp drives, bit i = approach i.
- ActiveDir  out  $clog2(NUM_DIR)  approach currently owning the cycle.
- Phase  out  3  0 ALL_RED, 1 RED_YELLOW, 2 GREEN, 3 YELLOW, 4 FLASH.

## Operation
- Registers: Phase, ActiveDir, Counter[CNT_W], Pending[NUM_DIR], Blink.
- Counter is 0 in the first cycle of every phase and increments by 1 each cycle. "Phase end" means Counter == T_x-1, so every timed phase lasts exactly T_x cycles.
- Lamps are decoded from registered state only; no combinational path from any input to any output.
  - ALL_RED: all Red=1.
  - RED_YELLOW: all Red=1; Yellow[ActiveDir]=1.
  - GREEN: Green[ActiveDir]=1; all other approaches Red=1.
  - YELLOW: Yellow[ActiveDir]=1; all other approaches Red=1.
  - FLASH: Red=Green=0; every Yellow bit = Blink.
- Pending update: Pending[i] <= Pending[i] | Request[i].
  - Exception: while Phase==GREEN, Request[ActiveDir] is not latched.
  - On entry to GREEN, Pending[ActiveDir] is cleared. The clear wins over a same-cycle request.
- Transitions:
  - ALL_RED end with FlashMode=1 → FLASH.
  - ALL_RED end otherwise → RED_YELLOW. ActiveDir becomes the first i with Pending[i]=1, searching ActiveDir+1, +2, … with wrap modulo NUM_DIR. If Pending is all zero, ActiveDir is unchanged.
  - RED_YELLOW end → GREEN, unconditionally.
  - GREEN with Counter ≥ T_GREEN-1 and (any Pending[j], j≠ActiveDir, or FlashMode) → YELLOW. Otherwise GREEN holds. The counter saturates at T_GREEN-1 while holding.
  - YELLOW end → ALL_RED, unconditionally. YELLOW is never truncated.
  - FLASH: Blink toggles at each FLASH end (Counter==T_FLASH-1), then Counter restarts at 0. Blink is 1 on FLASH entry. FlashMode=0 in FLASH → ALL_RED next cycle, Counter=0, ActiveDir unchanged.
- FlashMode never cuts GREEN, RED_YELLOW or YELLOW short beyond the rules above. A lamp is never switched from green to red without passing through yellow.
- Reset values: Phase=ALL_RED, ActiveDir=0, Counter=0, Pending=0, Blink=0. Outputs during reset are therefore all Red=1, Yellow=0, Green=0, ActiveDir=0, Phase=0.
- Reset mid-operation: all of the above are restored immediately (asynchronous assertion); in-flight requests are lost.

## Timing
- Cycle 0 is the first rising edge with Reset_N=1. Reset deassertion is treated as synchronous to Clock by the board reset synchroniser.
- Request-to-Pending latency: 1 cycle.
- Phase change occurs on the edge after the end condition holds. Outputs follow Phase in the same cycle.
- Minimum handoff, from last green cycle of approach A to first green cycle of approach B: T_YELLOW + T_ALL_RED + T_RED_YELLOW cycles.

## Test plan
All scenarios use NUM_DIR=3, T_ALL_RED=2, T_RED_YELLOW=2, T_GREEN=8, T_YELLOW=3, T_FLASH=4.
1. Reset release, no requests:
   - ALL_RED cycles 0-1; RED_YELLOW dir0 cycles 2-3; Green[0]=1 from cycle 4.
   - Holds indefinitely (checked to cycle 100); Red[2:1]=2'b11 throughout.
2. Request[2] pulsed for 1 cycle at cycle 5:
   - GREEN dir0 cycles 4-11; YELLOW 12-14; ALL_RED 15-16; RED_YELLOW dir2 17-18.
   - Green[2]=1 from cycle 19; Pending[2]=0 at cycle 19.
3. Round-robin wrap: with ActiveDir=2 in GREEN, pulse Request[0] and Request[1] together.
   - Next green is dir0, then dir1.
   - Request[2] held during dir2 GREEN does not cause re-service.
4. FlashMode=1 asserted at cycle 6 with no requests:
   - YELLOW 12-14, ALL_RED 15-16, FLASH from 17.
   - Yellow=3'b111 for cycles 17-20, 3'b000 for 21-24, repeating.
   - Deassert FlashMode → ALL_RED next cycle, then RED_YELLOW dir0.
5. Async reset mid-YELLOW (Reset_N low between edges):
   - Outputs go to Red=3'b111, Yellow=0, Green=0 before the next edge.
   - Pending is cleared; the cycle-0 sequence restarts.
6. Simultaneous events: Request[0] at the GREEN-entry cycle of dir0 is not retained. Request[1] arriving on the last ALL_RED cycle is not selected that round; it is latched 1 cycle later and served next.
